// File: rtl/issue_scoreboard_staller_pkg.sv
// Shared constants and types for the issue scoreboard staller.
// Optional store/load base-register alias check: SW_LW_ALIAS_CHECK_EN.
package issue_scoreboard_staller_pkg;

  localparam int ISSUE_WIDTH_DEF = 2;
  localparam int REG_AW_DEF      = 3;
  localparam int LOAD_LAT_DEF    = 2;
  localparam int PERF_W_DEF      = 16;
  // Scoreboard counter width; holds LOAD_LAT-1 for LOAD_LAT up to 7.
  localparam int SB_W            = 3;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2,
    CLS_NONE  = 2'd3
  } op_class_e;

  function automatic int src_w(input int reg_aw);
    return reg_aw + 1;
  endfunction

  function automatic op_class_e slot_class(input logic is_load, input logic is_store);
    if (is_load)       return CLS_LOAD;
    else if (is_store) return CLS_STORE;
    else               return CLS_ALU;
  endfunction

endpackage

// File: rtl/issue_scoreboard_staller_if.sv
// Decode-group interface between the ID_RF stage and the issue staller.
// Optional store/load alias check macro: SW_LW_ALIAS_CHECK_EN (no signals change).
interface issue_scoreboard_staller_if
  import issue_scoreboard_staller_pkg::*;
#(
  parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int PERF_W      = PERF_W_DEF
);
  localparam int SRC_W = src_w(REG_AW);

  // Handshake: the decoder holds every in_* field stable while enable is low.
  // issue_valid[k] high means slot k is accepted into RF_EX this cycle;
  // enable high means the whole group is consumed and a new one may follow.
  logic [ISSUE_WIDTH-1:0]        in_valid;
  logic [ISSUE_WIDTH*SRC_W-1:0]  in_src1;
  logic [ISSUE_WIDTH*SRC_W-1:0]  in_src2;
  logic [ISSUE_WIDTH*REG_AW-1:0] in_dest;
  logic [ISSUE_WIDTH-1:0]        in_dest_we;
  logic [ISSUE_WIDTH-1:0]        in_is_load;
  logic [ISSUE_WIDTH-1:0]        in_is_store;
  logic                          flush;
  logic [ISSUE_WIDTH-1:0]        issue_valid;
  logic                          enable;
  logic [PERF_W-1:0]             stall_cnt;
  logic [ISSUE_WIDTH-1:0]        dbg_issued_mask;

  modport master (
    output in_valid, in_src1, in_src2, in_dest, in_dest_we, in_is_load, in_is_store, flush,
    input  issue_valid, enable, stall_cnt, dbg_issued_mask
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_dest, in_dest_we, in_is_load, in_is_store, flush,
    output issue_valid, enable, stall_cnt, dbg_issued_mask
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register load-latency countdown scoreboard; busy[r] while sb[r] != 0.
// Issued writers set their destination counter, youngest slot winning.
module issue_scoreboard
  import issue_scoreboard_staller_pkg::*;
#(
  parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int LOAD_LAT    = LOAD_LAT_DEF
)(
  input  logic                               clock,
  input  logic                               reset,
  input  logic [ISSUE_WIDTH-1:0]             set_valid,
  input  logic [ISSUE_WIDTH-1:0][REG_AW-1:0] set_addr,
  input  logic [ISSUE_WIDTH-1:0]             set_is_load,
  output logic [2**REG_AW-1:0]               busy
);
  localparam int NUM_REGS = 2**REG_AW;
  localparam logic [SB_W-1:0] LOAD_SET = SB_W'(LOAD_LAT - 1);

  logic [SB_W-1:0] sb      [NUM_REGS];
  logic [SB_W-1:0] sb_next [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_next[r] = (sb[r] != '0) ? sb[r] - 1'b1 : '0;
      // Ascending slot order lets the youngest writer override older ones.
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (set_valid[k] && (set_addr[k] == REG_AW'(r)))
          sb_next[r] = set_is_load[k] ? LOAD_SET : '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) sb[r] <= '0;
      else       sb[r] <= sb_next[r];
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (sb[r] != '0);
  end

endmodule

// File: rtl/issue_scoreboard_staller.sv
// In-order prefix issue of an ISSUE_WIDTH decode group with split-issue hold.
// Define SW_LW_ALIAS_CHECK_EN to hold loads behind same-base older stores.
module issue_scoreboard_staller
  import issue_scoreboard_staller_pkg::*;
#(
  parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int LOAD_LAT    = LOAD_LAT_DEF,
  parameter int PERF_W      = PERF_W_DEF
)(
  input logic                        clock,
  input logic                        reset,
  issue_scoreboard_staller_if.slave  bus
);
  localparam int NUM_REGS = 2**REG_AW;
  localparam int SRC_W    = src_w(REG_AW);

  logic [ISSUE_WIDTH-1:0]             issued_mask;
  logic [ISSUE_WIDTH-1:0]             ready;
  logic [ISSUE_WIDTH-1:0]             prefix_iv;
  logic [ISSUE_WIDTH-1:0]             issue_valid;
  logic                               enable;
  logic                               older_ok;
  logic [NUM_REGS-1:0]                busy;
  logic [PERF_W-1:0]                  stall_cnt;
  logic [ISSUE_WIDTH-1:0][SRC_W-1:0]  src1;
  logic [ISSUE_WIDTH-1:0][SRC_W-1:0]  src2;
  logic [ISSUE_WIDTH-1:0][REG_AW-1:0] dest;

  assign src1 = bus.in_src1;
  assign src2 = bus.in_src2;
  assign dest = bus.in_dest;

  always_comb begin
    ready = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      ready[k] = bus.in_valid[k] & ~issued_mask[k];
      if (src1[k][SRC_W-1] && busy[src1[k][REG_AW-1:0]]) ready[k] = 1'b0;
      if (src2[k][SRC_W-1] && busy[src2[k][REG_AW-1:0]]) ready[k] = 1'b0;
      // No same-cycle forwarding: an older unissued writer blocks its readers.
      for (int j = 0; j < k; j++) begin
        if (bus.in_valid[j] && bus.in_dest_we[j] && !issued_mask[j]) begin
          if (src1[k][SRC_W-1] && (src1[k][REG_AW-1:0] == dest[j])) ready[k] = 1'b0;
          if (src2[k][SRC_W-1] && (src2[k][REG_AW-1:0] == dest[j])) ready[k] = 1'b0;
        end
`ifdef SW_LW_ALIAS_CHECK_EN
        if (bus.in_valid[j] && !issued_mask[j] &&
            (slot_class(bus.in_is_load[j], bus.in_is_store[j]) == CLS_STORE) &&
            (slot_class(bus.in_is_load[k], bus.in_is_store[k]) == CLS_LOAD) &&
            (src1[j][REG_AW-1:0] == src1[k][REG_AW-1:0]))
          ready[k] = 1'b0;
`endif
      end
    end
  end

`ifndef SW_LW_ALIAS_CHECK_EN
  logic unused_is_store;
  assign unused_is_store = ^bus.in_is_store;
`endif

  always_comb begin
    older_ok  = 1'b1;
    prefix_iv = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      prefix_iv[k] = ready[k] & older_ok;
      older_ok     = older_ok & (issued_mask[k] | prefix_iv[k] | ~bus.in_valid[k]);
    end
  end

  assign enable      = bus.flush | (&(issued_mask | prefix_iv | ~bus.in_valid));
  assign issue_valid = bus.flush ? '0 : prefix_iv;

  issue_scoreboard #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .REG_AW      (REG_AW),
    .LOAD_LAT    (LOAD_LAT)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .set_valid   (issue_valid & bus.in_dest_we),
    .set_addr    (dest),
    .set_is_load (bus.in_is_load),
    .busy        (busy)
  );

  always_ff @(posedge clock) begin
    if (reset)       issued_mask <= '0;
    else if (enable) issued_mask <= '0;
    else             issued_mask <= issued_mask | issue_valid;
  end

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt <= '0;
    else if (!enable && !bus.flush && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.issue_valid     = issue_valid;
  assign bus.enable          = enable;
  assign bus.stall_cnt       = stall_cnt;
  assign bus.dbg_issued_mask = issued_mask;

endmodule
